fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 114 +++++++++++
 tb/tb_fifo_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream for fifo_stream_reader.
// The master side is the reader; the slave side is the FIFO and downstream sink.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 32
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pulls words from a registered-output FIFO into a 2-entry skid buffer and
// presents them as a packetised valid/ready stream with a last-beat marker.
module fifo_stream_reader #(
  parameter int DATA_W  = 32,
  parameter int PKT_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic [15:0]          words_sent,
  output logic                 busy
);
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

  state_t            state_reg;
  logic [1:0]        occ_reg;
  logic              inflight_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [15:0]       words_sent_reg;
  logic [DATA_W-1:0] buf_q [BUF_DEPTH];

  logic       hs;
  logic       push;
  logic [1:0] wr_idx;

  assign hs     = bus.m_valid & bus.m_ready;
  assign push   = inflight_reg;
  // Tail slot after this cycle's pop has shifted the queue forward.
  assign wr_idx = occ_reg - {1'b0, hs};

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_buf
    logic [DATA_W-1:0] entry_reg;
    logic [DATA_W-1:0] shift_in;

    if (gi == BUF_DEPTH - 1) begin : g_tail
      assign shift_in = entry_reg;
    end else begin : g_mid
      assign shift_in = buf_q[gi+1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (push && wr_idx == 2'(gi)) begin
        entry_reg <= bus.fifo_data;
      end else if (hs) begin
        entry_reg <= shift_in;
      end
    end

    assign buf_q[gi] = entry_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      occ_reg        <= 2'd0;
      inflight_reg   <= 1'b0;
      beat_cnt_reg   <= '0;
      words_sent_reg <= 16'd0;
    end else begin
      // The read gap also hides the FIFO's one-cycle stale empty flag.
      inflight_reg <= bus.fifo_rd_en;

      case ({push, hs})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase

      if (hs) begin
        words_sent_reg <= words_sent_reg + 16'd1;
        if (beat_cnt_reg == LAST_BEAT) begin
          beat_cnt_reg <= '0;
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (enable) state_reg <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!enable) begin
            state_reg <= (occ_reg != 2'd0 || inflight_reg) ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (enable) begin
            state_reg <= ST_ACTIVE;
          end else if (occ_reg == 2'd0 && !inflight_reg) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = enable & ~bus.fifo_empty & ~inflight_reg &
                          (occ_reg < 2'd2) & (state_reg != ST_DRAIN) & ~rst;

  assign bus.m_data  = buf_q[0];
  assign bus.m_valid = (occ_reg != 2'd0);
  assign bus.m_last  = (beat_cnt_reg == LAST_BEAT);
  assign words_sent  = words_sent_reg;
  assign busy        = (occ_reg != 2'd0) | inflight_reg;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue-based FIFO and stream
// scoreboard checked every cycle, plus literal expectations per scenario.
module tb_fifo_stream_reader;
  localparam int DATA_W  = 32;
  localparam int PKT_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] words_sent;
  logic        busy;

  fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

  fifo_stream_reader #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .words_sent (words_sent),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] fifo_q [$];
  logic [31:0] exp_q [$];
  beat_t       log_q [$];
  int          rd_count = 0;
  bit          rd_prev = 1'b0;
  int          hs_total = 0;
  int          hs_beat = 0;
  bit          started = 1'b0;
  int          fifo_sz;
  logic [31:0] rd_word;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO with registered data and an empty flag that lags the pop by a cycle.
  always @(posedge clk) begin
    fifo_sz = fifo_q.size();
    if (rst) begin
      chk("rd_en_in_reset", bus.fifo_rd_en, 0);
      exp_q.delete();
      hs_total = 0;
      hs_beat  = 0;
      rd_prev  = 1'b0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        log_q.push_back('{bus.m_data, bus.m_last});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_total++;
        hs_beat++;
      end
      if (bus.fifo_rd_en) begin
        chk("rd_gap", rd_prev, 0);
        chk("underflow", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) begin
          rd_word = fifo_q.pop_front();
          bus.fifo_data <= rd_word;
          exp_q.push_back(rd_word);
        end
        rd_count++;
      end
      rd_prev = bus.fifo_rd_en;
    end
    bus.fifo_empty <= (fifo_sz == 0);
  end

  // Stream expectations: words leave in read order, valid once captured.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("words_sent", words_sent, hs_total & 32'hFFFF);
      chk("busy", busy, exp_q.size() != 0);
      chk("occ_bound", exp_q.size() <= 2, 1);
      chk("m_valid", bus.m_valid, exp_q.size() > (rd_prev ? 1 : 0));
      if (bus.m_valid && exp_q.size() != 0) begin
        chk("m_data", bus.m_data, exp_q[0]);
        chk("m_last", bus.m_last, (hs_beat % PKT_LEN) == PKT_LEN - 1);
      end
      if (stall_prev) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, prev_data);
        chk("hold_last", bus.m_last, prev_last);
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    bus.m_ready = 1'b0;
    step(2);
    fifo_q.delete();
    log_q.delete();
    rd_count = 0;
    rst = 1'b0;
    started = 1'b1;
  endtask

  task automatic wait_hs(string name, int cnt, int limit, output int n);
    n = 0;
    while (log_q.size() < cnt && n < limit) begin
      step(1);
      n++;
    end
    chk({name, "_done"}, log_q.size(), cnt);
  endtask

  int n;

  initial begin
    bus.m_ready = 1'b0;
    do_reset();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_words_sent", words_sent, 0);
    chk("rst_busy", busy, 0);

    // Scenario 1: eight preloaded words streamed at full rate.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
    enable = 1'b1;
    bus.m_ready = 1'b1;
    wait_hs("s1", 8, 40, n);
    chk("s1_cycles", n, 18);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) begin
        chk("s1_data", log_q[i].data, 32'(i + 1));
        chk("s1_last", log_q[i].last, i == 7);
      end
    end
    chk("s1_words_sent", words_sent, 8);

    // Scenario 2: sink stalled, buffer fills with two words.
    do_reset();
    fifo_q.push_back(32'd11);
    fifo_q.push_back(32'd12);
    fifo_q.push_back(32'd13);
    enable = 1'b1;
    step(10);
    chk("s2_reads_stalled", rd_count, 2);
    chk("s2_m_valid", bus.m_valid, 1);
    chk("s2_m_data", bus.m_data, 32'd11);
    bus.m_ready = 1'b1;
    step(1);
    bus.m_ready = 1'b0;
    step(6);
    chk("s2_reads_after_hs", rd_count, 3);
    bus.m_ready = 1'b1;
    wait_hs("s2", 3, 20, n);
    if (log_q.size() == 3) begin
      chk("s2_w0", log_q[0].data, 32'd11);
      chk("s2_w1", log_q[1].data, 32'd12);
      chk("s2_w2", log_q[2].data, 32'd13);
    end
    chk("s2_words_sent", words_sent, 3);

    // Scenario 3: single word into an empty FIFO.
    do_reset();
    enable = 1'b1;
    bus.m_ready = 1'b1;
    step(5);
    chk("s3_no_read_empty", rd_count, 0);
    fifo_q.push_back(32'hA5);
    step(10);
    chk("s3_one_read", rd_count, 1);
    chk("s3_one_word", log_q.size(), 1);
    if (log_q.size() != 0) chk("s3_data", log_q[0].data, 32'hA5);
    chk("s3_idle", busy, 0);

    // Scenario 4: enable dropped with one word buffered and one in flight.
    do_reset();
    for (int i = 21; i <= 24; i++) fifo_q.push_back(32'(i));
    enable = 1'b1;
    n = 0;
    while (rd_count < 2 && n < 20) begin
      step(1);
      n++;
    end
    chk("s4_two_reads", rd_count, 2);
    enable = 1'b0;
    bus.m_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      step(1);
      n++;
    end
    chk("s4_drained", busy, 0);
    chk("s4_delivered", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("s4_w0", log_q[0].data, 32'd21);
      chk("s4_w1", log_q[1].data, 32'd22);
    end
    step(5);
    chk("s4_no_more_reads", rd_count, 2);
    chk("s4_fifo_left", fifo_q.size(), 2);

    // Scenario 5: reset pulse with a full buffer, then a fresh packet.
    do_reset();
    fifo_q.push_back(32'd31);
    fifo_q.push_back(32'd32);
    fifo_q.push_back(32'd33);
    enable = 1'b1;
    step(8);
    chk("s5_full_valid", bus.m_valid, 1);
    chk("s5_full_busy", busy, 1);
    for (int i = 34; i <= 41; i++) fifo_q.push_back(32'(i));
    rst = 1'b1;
    step(1);
    chk("s5_rst_m_valid", bus.m_valid, 0);
    chk("s5_rst_words_sent", words_sent, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_m_last", bus.m_last, 0);
    rst = 1'b0;
    log_q.delete();
    bus.m_ready = 1'b1;
    wait_hs("s5", 8, 40, n);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) begin
        chk("s5_data", log_q[i].data, 32'(33 + i));
        chk("s5_last", log_q[i].last, i == 7);
      end
    end
    enable = 1'b0;
    step(4);

    // Scenario 6: counter preset to 65535, one more handshake wraps it.
    do_reset();
    enable = 1'b1;
    force dut.words_sent_reg = 16'hFFFF;
    hs_total = 65535;
    step(1);
    release dut.words_sent_reg;
    step(1);
    chk("s6_preset", words_sent, 16'hFFFF);
    fifo_q.push_back(32'h77);
    bus.m_ready = 1'b1;
    wait_hs("s6", 1, 20, n);
    chk("s6_wrap", words_sent, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
